// File: rtl/ehl_data_buffer_lvl.sv
// Small shift-register buffer with occupancy level, threshold flags and sticky errors.
// Optional same-cycle empty bypass is enabled by defining EHL_DATA_BUFFER_BYPASS_EN.
module ehl_data_buffer_lvl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int MODE       = 0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);
  localparam logic [LW-1:0] ONE     = LW'(1);

  logic [DATA_WIDTH-1:0] slot [DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  bypass_hit;
  logic                  ov_set;
  logic                  un_set;
  logic [LW-1:0]         level_nxt;

  // Occupancy update that can never wrap past empty or full.
  function automatic logic [LW-1:0] level_step(input logic [LW-1:0] lvl,
                                               input logic inc,
                                               input logic dec);
    logic [LW-1:0] r;
    r = lvl;
    if (inc && !dec && (lvl != DEPTH_L))
      r = lvl + ONE;
    else if (dec && !inc && (lvl != '0))
      r = lvl - ONE;
    return r;
  endfunction

  // Request qualification: read is resolved first so a full buffer can accept wr+rd.
  always_comb begin
    bypass_hit = 1'b0;
`ifdef EHL_DATA_BUFFER_BYPASS_EN
    bypass_hit = !clear && wr && rd && empty;
`endif
    rd_ok  = !clear && rd && !empty;
    wr_ok  = !clear && wr && !bypass_hit && (!full || rd_ok);
    ov_set = !clear && wr && full && !rd_ok;
    un_set = !clear && rd && empty && !bypass_hit;
    level_nxt = clear ? '0 : level_step(level, wr_ok, rd_ok);
  end

  // Control state: level and every flag registered from the next level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= level_nxt;
      empty        <= (level_nxt == '0);
      full         <= (level_nxt == DEPTH_L);
      almost_empty <= (level_nxt <= AE_L);
      almost_full  <= (level_nxt >= AF_L);
      overflow     <= clear ? 1'b0 : (overflow | ov_set);
      underflow    <= clear ? 1'b0 : (underflow | un_set);
    end
  end

  generate
    if (MODE == 0) begin : g_mode0
      // Head sits in slot 0; a read shifts toward it, a write lands just past the tail.
      logic [LW-1:0] wr_idx;
      assign wr_idx = rd_ok ? (level - ONE) : level;
      assign head   = slot[0];

      always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_ok && (wr_idx == LW'(i)))
            slot[i] <= data_in;
          else if (rd_ok && (i < DEPTH - 1))
            slot[i] <= slot[(i < DEPTH - 1) ? i + 1 : i];
        end
      end
    end else begin : g_mode1
      // New words always enter slot 0; the oldest word sits at slot level-1.
      logic [LW-1:0] rd_idx;
      assign rd_idx = (level == '0) ? '0 : (level - ONE);
      assign head   = slot[rd_idx];

      always_ff @(posedge clk) begin
        if (wr_ok) begin
          slot[0] <= data_in;
          for (int i = 1; i < DEPTH; i++)
            slot[i] <= slot[i-1];
        end
      end
    end
  endgenerate

`ifdef EHL_DATA_BUFFER_BYPASS_EN
  assign data_out = bypass_hit ? data_in : head;
`else
  assign data_out = head;
`endif

endmodule

// File: tb/tb_ehl_data_buffer_lvl.sv
// Directed bench: three DEPTH=5 buffers (mode 0, mode 1, mode 0 with AF=3) on shared stimulus.
module tb_ehl_data_buffer_lvl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        wr;
  logic        rd;
  logic [15:0] data_in;

  logic [15:0] a_data_out, b_data_out, c_data_out;
  logic        a_empty, b_empty, c_empty;
  logic        a_full, b_full, c_full;
  logic        a_ae, b_ae, c_ae;
  logic        a_af, b_af, c_af;
  logic [2:0]  a_level, b_level, c_level;
  logic        a_ov, b_ov, c_ov;
  logic        a_un, b_un, c_un;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ehl_data_buffer_lvl #(.DATA_WIDTH(16), .DEPTH(5), .MODE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(a_data_out), .empty(a_empty), .full(a_full), .almost_empty(a_ae),
    .almost_full(a_af), .level(a_level), .overflow(a_ov), .underflow(a_un));

  ehl_data_buffer_lvl #(.DATA_WIDTH(16), .DEPTH(5), .MODE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(b_data_out), .empty(b_empty), .full(b_full), .almost_empty(b_ae),
    .almost_full(b_af), .level(b_level), .overflow(b_ov), .underflow(b_un));

  ehl_data_buffer_lvl #(.DATA_WIDTH(16), .DEPTH(5), .MODE(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(c_data_out), .empty(c_empty), .full(c_full), .almost_empty(c_ae),
    .almost_full(c_af), .level(c_level), .overflow(c_ov), .underflow(c_un));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr = 1'b1; data_in = d;
    cyc();
    wr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    cyc();
    rd = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_level, a_empty, a_full, a_ae, a_af, a_ov, a_un} !== 9'b000_1_0_1_0_0_0) begin
      n_fail++;
      $display("FAIL reset_a got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want lvl=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
               a_level, a_empty, a_full, a_ae, a_af, a_ov, a_un);
    end
    n_tests++;
    if ({b_level, b_empty, b_full, b_ae, b_af, b_ov, b_un} !== 9'b000_1_0_1_0_0_0) begin
      n_fail++;
      $display("FAIL reset_b got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want lvl=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
               b_level, b_empty, b_full, b_ae, b_af, b_ov, b_un);
    end
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_d;
    for (int k = 1; k <= 5; k++) begin
      push(16'(k * 17));
      n_tests++;
      if (a_level !== 3'(k) || b_level !== 3'(k)) begin
        n_fail++;
        $display("FAIL fill_level got a=%0d b=%0d want %0d", a_level, b_level, k);
      end
    end
    n_tests++;
    if (a_full !== 1'b1 || b_full !== 1'b1 || a_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got a_full=%b b_full=%b a_empty=%b want 1 1 0", a_full, b_full, a_empty);
    end
    push(16'h0066);
    n_tests++;
    if (a_ov !== 1'b1 || b_ov !== 1'b1 || a_level !== 3'd5 || b_level !== 3'd5) begin
      n_fail++;
      $display("FAIL overflow got a_ov=%b b_ov=%b a_lvl=%0d b_lvl=%0d want 1 1 5 5", a_ov, b_ov, a_level, b_level);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_d = 16'(k * 17);
      n_tests++;
      if (a_data_out !== exp_d || b_data_out !== exp_d) begin
        n_fail++;
        $display("FAIL drain_data[%0d] got a=%h b=%h want %h", k, a_data_out, b_data_out, exp_d);
      end
      pop();
    end
    n_tests++;
    if (a_empty !== 1'b1 || b_empty !== 1'b1 || a_level !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty got a_e=%b b_e=%b a_lvl=%0d want 1 1 0", a_empty, b_empty, a_level);
    end
  endtask

  task automatic test_underflow();
    pop();
    n_tests++;
    if (a_un !== 1'b1 || b_un !== 1'b1 || a_level !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow got a_un=%b b_un=%b a_lvl=%0d want 1 1 0", a_un, b_un, a_level);
    end
    do_clear();
    n_tests++;
    if (a_un !== 1'b0 || a_ov !== 1'b0 || b_un !== 1'b0 || b_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_errors got a_un=%b a_ov=%b b_un=%b b_ov=%b want 0 0 0 0", a_un, a_ov, b_un, b_ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [5];
    exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h00A5};
    for (int k = 1; k <= 5; k++) push(16'(k));
    wr = 1'b1; rd = 1'b1; data_in = 16'h00A5;
    cyc();
    wr = 1'b0; rd = 1'b0;
    n_tests++;
    if (a_level !== 3'd5 || b_level !== 3'd5 || a_ov !== 1'b0 || b_ov !== 1'b0 || a_full !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rd_full got a_lvl=%0d b_lvl=%0d a_ov=%b b_ov=%b a_full=%b want 5 5 0 0 1",
               a_level, b_level, a_ov, b_ov, a_full);
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (a_data_out !== exp_q[k] || b_data_out !== exp_q[k]) begin
        n_fail++;
        $display("FAIL b2b_data[%0d] got a=%h b=%h want %h", k, a_data_out, b_data_out, exp_q[k]);
      end
      pop();
    end
  endtask

  task automatic test_thresholds();
    do_clear();
    for (int k = 1; k <= 3; k++) begin
      push(16'(k + 32));
      n_tests++;
      if (c_ae !== (k <= 1) || c_af !== (k >= 3) || a_af !== 1'b0) begin
        n_fail++;
        $display("FAIL thresholds[%0d] got c_ae=%b c_af=%b a_af=%b want %b %b 0",
                 k, c_ae, c_af, a_af, (k <= 1), (k >= 3));
      end
    end
    push(16'h0024);
    n_tests++;
    if (a_af !== 1'b1) begin
      n_fail++;
      $display("FAIL af_default got a_af=%b want 1", a_af);
    end
    do_clear();
  endtask

  task automatic test_bypass();
    wr = 1'b1; rd = 1'b1; data_in = 16'h003C;
    #1;
`ifdef EHL_DATA_BUFFER_BYPASS_EN
    n_tests++;
    if (a_data_out !== 16'h003C || b_data_out !== 16'h003C) begin
      n_fail++;
      $display("FAIL bypass_comb got a=%h b=%h want 003c", a_data_out, b_data_out);
    end
    cyc();
    wr = 1'b0; rd = 1'b0;
    n_tests++;
    if (a_level !== 3'd0 || a_un !== 1'b0 || b_level !== 3'd0 || b_un !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_state got a_lvl=%0d a_un=%b b_lvl=%0d b_un=%b want 0 0 0 0",
               a_level, a_un, b_level, b_un);
    end
`else
    cyc();
    wr = 1'b0; rd = 1'b0;
    n_tests++;
    if (a_level !== 3'd1 || a_un !== 1'b1 || b_level !== 3'd1 || b_un !== 1'b1) begin
      n_fail++;
      $display("FAIL nobypass_state got a_lvl=%0d a_un=%b b_lvl=%0d b_un=%b want 1 1 1 1",
               a_level, a_un, b_level, b_un);
    end
    n_tests++;
    if (a_data_out !== 16'h003C || b_data_out !== 16'h003C || a_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass_data got a=%h b=%h a_empty=%b want 003c 003c 0", a_data_out, b_data_out, a_empty);
    end
`endif
    do_clear();
  endtask

  task automatic test_clear_with_wr();
    for (int k = 1; k <= 6; k++) push(16'(k + 64));
    pop();
    pop();
    n_tests++;
    if (a_level !== 3'd3 || a_ov !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clear got a_lvl=%0d a_ov=%b want 3 1", a_level, a_ov);
    end
    clear = 1'b1; wr = 1'b1; data_in = 16'h0099;
    cyc();
    clear = 1'b0; wr = 1'b0;
    n_tests++;
    if (a_level !== 3'd0 || a_empty !== 1'b1 || a_ov !== 1'b0 || a_un !== 1'b0 ||
        b_level !== 3'd0 || b_ov !== 1'b0 || a_ae !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_wr got a_lvl=%0d a_e=%b a_ov=%b a_un=%b b_lvl=%0d b_ov=%b a_ae=%b want 0 1 0 0 0 0 1",
               a_level, a_empty, a_ov, a_un, b_level, b_ov, a_ae);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 1; k <= 5; k++) push(16'(k + 80));
    push(16'h00EE);
    wr = 1'b1; data_in = 16'h0044;
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a_level, a_empty, a_full, a_ae, a_af, a_ov, a_un} !== 9'b000_1_0_1_0_0_0 ||
        {b_level, b_empty, b_full} !== 5'b000_1_0) begin
      n_fail++;
      $display("FAIL async_reset got a lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b b lvl=%0d e=%b f=%b",
               a_level, a_empty, a_full, a_ae, a_af, a_ov, a_un, b_level, b_empty, b_full);
    end
    wr = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    push(16'h0077);
    n_tests++;
    if (a_level !== 3'd1 || a_empty !== 1'b0 || a_data_out !== 16'h0077 || b_data_out !== 16'h0077) begin
      n_fail++;
      $display("FAIL post_reset_write got a_lvl=%0d a_e=%b a=%h b=%h want 1 0 0077 0077",
               a_level, a_empty, a_data_out, b_data_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    cyc();
    cyc();
    test_reset();
    reset_n = 1'b1;
    cyc();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_thresholds();
    test_bypass();
    test_clear_with_wr();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ehl_data_buffer_lvl.md
# ehl_data_buffer_lvl

Parametrised successor to the two-mode shift data buffer. Adds arbitrary (non-power-of-two) depth, an occupancy level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow errors with internal protection, and a synchronous flush. Sits between producer and consumer datapaths where a small FIFO-like buffer is needed and either the read path or the write path must stay minimal.

## Interface
- DATA_WIDTH, 16, data word width (1..1024)
- DEPTH, 4, number of entries (2..256, any integer)
- MODE, 0, 0 = load-by-pointer/read-by-shift (data_out from slot 0); 1 = load-by-shift/read-by-pointer (data_in always into slot 0)
- AF_LEVEL, DEPTH-1, almost_full asserted when level >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
- LW (localparam), $clog2(DEPTH+1), level width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush; empties buffer, clears errors
- wr  in  1  write request
- rd  in  1  read request
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  head-of-buffer data
- empty  out  1  registered, level == 0
- full  out  1  registered, level == DEPTH
- almost_empty  out  1  registered, level <= AE_LEVEL
- almost_full  out  1  registered, level >= AF_LEVEL
- level  out  LW  registered occupancy
- overflow  out  1  sticky: write refused
- underflow  out  1  sticky: read refused

## Operation
- Effective strobes: wr_ok = wr & (!full | rd_ok); rd_ok = rd & !empty. Order: rd_ok is evaluated first; wr_ok then uses it.
- wr & full & !rd: write dropped, storage and level unchanged, overflow <= 1.
- rd & empty: read dropped, underflow <= 1. With BYPASS (see Configuration), the wr & rd & empty case is instead accepted.
- wr_ok & rd_ok: level unchanged. Oldest word leaves and new word enters the correct slot:
  - MODE 0: write at slot level-1 after shift.
  - MODE 1: shift in; read pointer unchanged.
- wr_ok only: level+1. rd_ok only: level-1. Level never wraps.
- MODE 0: data_out = slot[0]; rd shifts slot[i] <= slot[i+1].
- MODE 1: data_out = slot[level-1]; wr shifts slot[i] <= slot[i-1], slot[0] <= data_in.
- data_out is undefined (previous contents, not X-forced) while empty. Data storage has no reset; only control/valid state is reset.
- clear has priority over wr/rd in the same cycle: level <= 0, flags reset, overflow/underflow <= 0, the wr/rd of that cycle is ignored.
- All flags are computed from next-level and registered; no combinational path from wr/rd to any flag.

## Timing
- Reset values: level 0, empty 1, full 0, almost_empty 1 (AE_LEVEL >= 0), almost_full 0, overflow 0, underflow 0, data_out don't-care.
- Write at edge N into an empty buffer: data_out valid and empty = 0 after edge N (cycle N+1). Latency is 1.
- Flags and level reflect all wr/rd accepted at edge N from cycle N+1 onward.
- Errors set on the edge of the offending request; they hold until clear or reset.
- Reset asserted mid-operation: all control state returns to reset values immediately (asynchronous). The first write after deassertion behaves as into an empty buffer.

## Configuration
- EHL_DATA_BUFFER_BYPASS_EN:
  - Defined: when empty and wr & rd are both high, data_in drives data_out combinationally in the same cycle. The word is consumed, level stays 0, and no underflow is flagged.
  - Undefined: there is no combinational path from data_in to data_out. In that case rd is refused (underflow <= 1) and the write is accepted (level becomes 1).

## Test plan
- DEPTH=5, MODE 0: 5 writes 0x11..0x55 → full=1 and level=5. A 6th write of 0x66 → overflow=1, level=5. 5 reads return 0x11..0x55 in order, then empty=1.
- DEPTH=5, MODE 1: same sequence → identical data_out order and flags. Confirms mode equivalence.
- Full buffer, wr & rd simultaneously with 0xA5 → level stays 5, no overflow. 0xA5 is read last.
- AF_LEVEL=3, AE_LEVEL=1: fill one by one → almost_full rises the cycle after the 3rd write, and almost_empty falls after the 2nd write.
- Empty, wr & rd with data_in=0x3C → with macro: data_out=0x3C same cycle, level 0. Without macro: underflow=1, level 1, data_out=0x3C next cycle.
- level=3, clear together with wr → level 0, empty 1, errors 0. Assert reset_n low mid-burst → all outputs return to reset values at once.
